alu_issue_unit: RTL

//  Drives the 32-bit ALU through a valid/ready handshake. Accepts a {ALUOp, funct, A, B} request from the datapath

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_op_decoder.sv | 47 ++++
 rtl/alu_issue_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU issue unit and the ALU itself:
//   - 4-bit ALUOperation codes presented to the ALU
//   - 3-bit ALUOp class codes coming from main control
//   - 6-bit R-type funct codes
//   - issue FSM state encoding (also exported on the debug port)
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALUOperation codes (must match the ALU's decode)
    localparam logic [3:0] OP_AND      = 4'b0000;
    localparam logic [3:0] OP_OR       = 4'b0001;
    localparam logic [3:0] OP_NOR      = 4'b0010;
    localparam logic [3:0] OP_ADD      = 4'b0011;
    localparam logic [3:0] OP_SUB      = 4'b0100;
    localparam logic [3:0] OP_INC      = 4'b1001;
    localparam logic [3:0] OP_MULTPLUS = 4'b1010;
    localparam logic [3:0] OP_ILLEGAL  = 4'b1111;

    // ALUOp classes from main control
    localparam logic [2:0] CLS_ADD   = 3'b000;
    localparam logic [2:0] CLS_SUB   = 3'b001;
    localparam logic [2:0] CLS_RTYPE = 3'b010;
    localparam logic [2:0] CLS_AND   = 3'b011;
    localparam logic [2:0] CLS_OR    = 3'b100;

    // R-type funct codes
    localparam logic [5:0] FN_ADD      = 6'h20;
    localparam logic [5:0] FN_SUB      = 6'h22;
    localparam logic [5:0] FN_AND      = 6'h24;
    localparam logic [5:0] FN_OR       = 6'h25;
    localparam logic [5:0] FN_NOR      = 6'h27;
    localparam logic [5:0] FN_INC      = 6'h30;
    localparam logic [5:0] FN_MULTPLUS = 6'h31;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
// Combinational decode of {ALUOp class, funct} into the ALUOperation code.
// Ports:
//   alu_op_i   [2:0]  class from main control
//   funct_i    [5:0]  R-type funct field (only used for class 010)
//   code_o     [3:0]  ALUOperation code for the ALU
//   is_mult_o         code is MULTPLUS (needs the long execute window)
//   illegal_o         request does not map to any ALU operation
// ---------------------------------------------------------------------------
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [2:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] code_o,
    output logic       is_mult_o,
    output logic       illegal_o
);

    always_comb begin
        code_o = OP_ILLEGAL;
        case (alu_op_i)
            CLS_ADD: code_o = OP_ADD;
            CLS_SUB: code_o = OP_SUB;
            CLS_AND: code_o = OP_AND;
            CLS_OR:  code_o = OP_OR;
            CLS_RTYPE: begin
                case (funct_i)
                    FN_ADD:      code_o = OP_ADD;
                    FN_SUB:      code_o = OP_SUB;
                    FN_AND:      code_o = OP_AND;
                    FN_OR:       code_o = OP_OR;
                    FN_NOR:      code_o = OP_NOR;
                    FN_INC:      code_o = OP_INC;
                    FN_MULTPLUS: code_o = OP_MULTPLUS;
                    default:     code_o = OP_ILLEGAL;
                endcase
            end
            default: code_o = OP_ILLEGAL;
        endcase
    end

    assign is_mult_o = (code_o == OP_MULTPLUS);
    assign illegal_o = (code_o == OP_ILLEGAL);

endmodule

// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
// Issues one request at a time to a combinational 32-bit ALU. The decoded
// code and operands are held in registers for the whole execute window so
// the ALU can be timed as a multi-cycle path; the result is captured at the
// end of the window and held until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and stays high with stable data until out_ready is seen.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_alu_op, in_funct   request class and R-type funct
//   in_a, in_b            request operands
//   alu_operation         registered ALUOperation code to the ALU
//   alu_a, alu_b          registered operands to the ALU
//   alu_result, alu_zero  combinational ALU outputs
//   out_valid/out_ready   result handshake
//   out_result, out_zero  captured ALU outputs
//   out_error             request decoded to ILLEGAL
//   dbg_state             current FSM state (alu_pkg::state_e encoding)
// ---------------------------------------------------------------------------
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MULT_CYCLES = 3,  // 1..15
    parameter int BASE_CYCLES = 1   // 1..15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_alu_op,
    input  logic [5:0]            in_funct,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [3:0]            alu_operation,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_error,
    output logic [1:0]            dbg_state
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] BASE_LOAD = 4'(BASE_CYCLES);

    state_e state_q, state_d;

    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  err_q;

    logic [3:0] dec_code;
    logic       dec_is_mult;
    logic       dec_illegal;
    logic       accept;
    logic       last_exec;

    alu_op_decoder u_dec (
        .alu_op_i  (in_alu_op),
        .funct_i   (in_funct),
        .code_o    (dec_code),
        .is_mult_o (dec_is_mult),
        .illegal_o (dec_illegal)
    );

    assign accept    = (state_q == ST_IDLE) && in_valid;
    assign last_exec = (state_q == ST_EXEC) && (cnt_q == 4'd1);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == 4'd1) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath. Operand/code registers only load on accept, so the ALU
    // inputs are frozen for the whole execute window and while the result
    // waits in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_ILLEGAL;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= 4'd0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= dec_code;
                a_q   <= in_a;
                b_q   <= in_b;
                cnt_q <= dec_is_mult ? MULT_LOAD : BASE_LOAD;
                err_q <= dec_illegal;
            end else if (state_q == ST_EXEC) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (last_exec) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

    assign alu_operation = op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign out_result    = result_q;
    assign out_zero      = zero_q;
    assign out_error     = err_q;
    assign dbg_state     = state_q;

endmodule
